// File: rtl/vga_timing.sv
// VGA raster timing generator: divides CLOCK_50 into a pixel clock, runs the
// raw horizontal/vertical counters from the sync-pulse origin, decodes
// sync/blank and delays them to line up with a pipelined renderer's colour.
// PIPE_DELAY is meant to be within 1..4. The counters are 10 bits wide, so
// H_TOTAL and V_TOTAL must not exceed 1024.
module vga_timing #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIPE_DELAY = 1
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  output logic        VGA_CLK,
  output logic [9:0]  VGA_X,
  output logic [9:0]  VGA_Y,
  input  logic [7:0]  R_IN,
  input  logic [7:0]  G_IN,
  input  logic [7:0]  B_IN,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_END  = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_END  = 10'(V_SYNC);
  localparam logic [9:0] H_VIS_START = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_VIS_END   = 10'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0] V_VIS_START = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_VIS_END   = 10'(V_SYNC + V_BP + V_ACTIVE);

  logic                  vga_clk_q, vga_clk_d;
  logic [9:0]            x_q, x_d;
  logic [9:0]            y_q, y_d;
  logic [PIPE_DELAY:0]   hs_pipe_q, hs_pipe_d;
  logic [PIPE_DELAY:0]   vs_pipe_q, vs_pipe_d;
  logic [PIPE_DELAY:0]   blank_pipe_q, blank_pipe_d;
  logic [7:0]            r_q, r_d;
  logic [7:0]            g_q, g_d;
  logic [7:0]            b_q, b_d;
  logic                  frame_start_q, frame_start_d;
  logic [15:0]           frame_count_q, frame_count_d;

  logic ce;
  logic hs_now;
  logic vs_now;
  logic blank_now;

  // The pixel tick is the cycle in which the divided clock is high, so the
  // counters move on VGA_CLK falling edges and are stable at its rising edges.
  assign ce = vga_clk_q;

  assign hs_now    = (x_q < H_SYNC_END);
  assign vs_now    = (y_q < V_SYNC_END);
  assign blank_now = (x_q >= H_VIS_START) && (x_q < H_VIS_END) &&
                     (y_q >= V_VIS_START) && (y_q < V_VIS_END);

  // Pixel clock divider plus the raster counters and the per-frame bookkeeping.
  always_comb begin
    vga_clk_d     = ~vga_clk_q;
    x_d           = x_q;
    y_d           = y_q;
    frame_start_d = 1'b0;
    frame_count_d = frame_count_q;
    if (ce) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        if (y_q == V_LAST) begin
          y_d           = '0;
          frame_start_d = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
        end else begin
          y_d = y_q + 10'd1;
        end
      end else begin
        x_d = x_q + 10'd1;
      end
    end
  end

  // Sync/blank delay line and the colour register gated by the blank state of
  // the same pixel the renderer is currently returning colour for.
  always_comb begin
    hs_pipe_d    = hs_pipe_q;
    vs_pipe_d    = vs_pipe_q;
    blank_pipe_d = blank_pipe_q;
    r_d          = r_q;
    g_d          = g_q;
    b_d          = b_q;
    if (ce) begin
      hs_pipe_d    = {hs_pipe_q[PIPE_DELAY-1:0], hs_now};
      vs_pipe_d    = {vs_pipe_q[PIPE_DELAY-1:0], vs_now};
      blank_pipe_d = {blank_pipe_q[PIPE_DELAY-1:0], blank_now};
      if (blank_pipe_q[PIPE_DELAY-1]) begin
        r_d = R_IN;
        g_d = G_IN;
        b_d = B_IN;
      end else begin
        r_d = 8'd0;
        g_d = 8'd0;
        b_d = 8'd0;
      end
    end
  end

  // State registers, cleared immediately when reset is pulled low.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      vga_clk_q     <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      hs_pipe_q     <= '0;
      vs_pipe_q     <= '0;
      blank_pipe_q  <= '0;
      r_q           <= 8'd0;
      g_q           <= 8'd0;
      b_q           <= 8'd0;
      frame_start_q <= 1'b0;
      frame_count_q <= 16'd0;
    end else begin
      vga_clk_q     <= vga_clk_d;
      x_q           <= x_d;
      y_q           <= y_d;
      hs_pipe_q     <= hs_pipe_d;
      vs_pipe_q     <= vs_pipe_d;
      blank_pipe_q  <= blank_pipe_d;
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign VGA_CLK     = vga_clk_q;
  assign VGA_X       = x_q;
  assign VGA_Y       = y_q;
  assign VGA_HS      = ~hs_pipe_q[PIPE_DELAY];
  assign VGA_VS      = ~vs_pipe_q[PIPE_DELAY];
  assign VGA_BLANK_N = blank_pipe_q[PIPE_DELAY];
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_R       = r_q;
  assign VGA_G       = g_q;
  assign VGA_B       = b_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing.sv
// Testbench for vga_timing: a shrunken-raster instance (PIPE_DELAY=2) is run
// over whole frames against an arithmetic raster model, and a default-size
// instance is checked over its first lines.
module tb_vga_timing;

  localparam int HA = 16, HF = 3, HSY = 5, HB = 4;
  localparam int VA = 6,  VF = 2, VSY = 2, VB = 3;
  localparam int PD = 2;
  localparam int HT = HSY + HB + HA + HF;
  localparam int VT = VSY + VB + VA + VF;
  localparam int FRAME = HT * VT;
  localparam int HVS = HSY + HB;
  localparam int VVS = VSY + VB;
  localparam int FULL_RUN = 2 * (2 * FRAME + PD + 4);

  localparam int D_HT = 800;
  localparam int D_PD = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [7:0]  r_in = 8'd0, g_in = 8'd0, b_in = 8'd0;
  logic        s_clk, s_hs, s_vs, s_blank_n, s_sync_n, s_fs;
  logic [9:0]  s_x, s_y;
  logic [7:0]  s_r, s_g, s_b;
  logic [15:0] s_fc;

  logic [7:0]  d_r_in = 8'hFF, d_g_in = 8'hFF, d_b_in = 8'hFF;
  logic        d_clk, d_hs, d_vs, d_blank_n, d_sync_n, d_fs;
  logic [9:0]  d_x, d_y;
  logic [7:0]  d_r, d_g, d_b;
  logic [15:0] d_fc;

  int tests_run = 0;
  int tests_failed = 0;
  logic [7:0] seed_r, seed_g, seed_b;

  localparam logic [65:0] RESET_VEC = {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0,
                                       24'd0, 1'b0, 16'd0, 1'b0};

  vga_timing #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .PIPE_DELAY(PD)
  ) dut (
    .CLOCK_50(clk), .reset(rst_n), .VGA_CLK(s_clk), .VGA_X(s_x), .VGA_Y(s_y),
    .R_IN(r_in), .G_IN(g_in), .B_IN(b_in),
    .VGA_R(s_r), .VGA_G(s_g), .VGA_B(s_b),
    .VGA_HS(s_hs), .VGA_VS(s_vs), .VGA_BLANK_N(s_blank_n), .VGA_SYNC_N(s_sync_n),
    .frame_start(s_fs), .frame_count(s_fc)
  );

  vga_timing dut_default (
    .CLOCK_50(clk), .reset(rst_n), .VGA_CLK(d_clk), .VGA_X(d_x), .VGA_Y(d_y),
    .R_IN(d_r_in), .G_IN(d_g_in), .B_IN(d_b_in),
    .VGA_R(d_r), .VGA_G(d_g), .VGA_B(d_b),
    .VGA_HS(d_hs), .VGA_VS(d_vs), .VGA_BLANK_N(d_blank_n), .VGA_SYNC_N(d_sync_n),
    .frame_start(d_fs), .frame_count(d_fc)
  );

  always #10 clk = ~clk;

  // Colour the pretend renderer produces for a given raster position.
  function automatic logic [23:0] pixel_colour(input int mode, input int idx);
    int px, py;
    logic [7:0] r, g, b;
    px = idx % HT;
    py = idx / HT;
    case (mode)
      1: begin r = 8'hFF; g = 8'hFF; b = 8'hFF; end
      2: begin r = 8'(px); g = 8'(py); b = 8'(px + py); end
      default: begin
        r = 8'(px * 37 + py * 11) ^ seed_r;
        g = 8'(px * 13 + py * 71) + seed_g;
        b = 8'(px ^ (py << 3)) ^ seed_b;
      end
    endcase
    return {r, g, b};
  endfunction

  // Runs the small instance from a fresh release and compares every cycle.
  task automatic run_frames_checked(input int mode, input int n_edges, input string tag);
    int t, c, q, qq, qx, qy, src, k;
    logic ehs_n, evs_n, eblank, efs;
    logic [9:0] ex, ey;
    logic [15:0] efc;
    logic [23:0] ergb, drv;
    int hs_low = 0, vs_low = 0, blank_hi = 0, fs_seen = 0;
    logic first_vis_seen = 1'b0;
    logic [7:0] first_vis_r = 8'd0;
    for (int e = 0; e <= n_edges; e++) begin
      t = e / 2;
      c = t % FRAME;
      ex = 10'(c % HT);
      ey = 10'(c / HT);
      q = t - 1 - PD;
      if (q >= 0) begin
        qq = q % FRAME; qx = qq % HT; qy = qq / HT;
        ehs_n  = !(qx < HSY);
        evs_n  = !(qy < VSY);
        eblank = (qx >= HVS) && (qx < HVS + HA) && (qy >= VVS) && (qy < VVS + VA);
        ergb   = eblank ? pixel_colour(mode, qq) : 24'd0;
      end else begin
        ehs_n = 1'b1; evs_n = 1'b1; eblank = 1'b0; ergb = 24'd0;
      end
      efs = (e % 2 == 0) && (t > 0) && (t % FRAME == 0);
      efc = 16'(t / FRAME);

      tests_run++;
      if (s_clk !== 1'(e % 2)) begin tests_failed++;
        $display("[TB] FAIL %s vga_clk e=%0d got %0b want %0b", tag, e, s_clk, 1'(e % 2)); end
      tests_run++;
      if ({s_x, s_y} !== {ex, ey}) begin tests_failed++;
        $display("[TB] FAIL %s xy e=%0d got (%0d,%0d) want (%0d,%0d)", tag, e, s_x, s_y, ex, ey); end
      tests_run++;
      if ({s_hs, s_vs, s_blank_n, s_sync_n} !== {ehs_n, evs_n, eblank, 1'b0}) begin tests_failed++;
        $display("[TB] FAIL %s hs/vs/blank/sync e=%0d got %b want %b", tag, e,
                 {s_hs, s_vs, s_blank_n, s_sync_n}, {ehs_n, evs_n, eblank, 1'b0}); end
      tests_run++;
      if ({s_r, s_g, s_b} !== ergb) begin tests_failed++;
        $display("[TB] FAIL %s rgb e=%0d got %h want %h", tag, e, {s_r, s_g, s_b}, ergb); end
      tests_run++;
      if ({s_fs, s_fc} !== {efs, efc}) begin tests_failed++;
        $display("[TB] FAIL %s frame e=%0d got fs=%0b fc=%0d want fs=%0b fc=%0d", tag, e,
                 s_fs, s_fc, efs, efc); end

      if ((e % 2 == 0) && (t >= 1 + PD) && (t < 1 + PD + FRAME)) begin
        if (s_hs == 1'b0) hs_low++;
        if (s_vs == 1'b0) vs_low++;
        if (s_blank_n == 1'b1) begin
          blank_hi++;
          if (!first_vis_seen) begin first_vis_seen = 1'b1; first_vis_r = s_r; end
        end
      end
      if ((t >= 1) && (t <= FRAME) && (s_fs == 1'b1)) fs_seen++;

      if ((e + 1) % 2 == 0) begin
        k = (e + 1) / 2;
        src = (k - 1) - PD;
        drv = (src >= 0) ? pixel_colour(mode, src % FRAME) : 24'($urandom);
      end else begin
        drv = (mode == 1) ? 24'hFFFFFF : 24'($urandom);
      end
      {r_in, g_in, b_in} = drv;
      @(posedge clk);
      @(negedge clk);
    end

    tests_run++;
    if (hs_low != VT * HSY) begin tests_failed++;
      $display("[TB] FAIL %s hs_low_ticks got %0d want %0d", tag, hs_low, VT * HSY); end
    tests_run++;
    if (vs_low != VSY * HT) begin tests_failed++;
      $display("[TB] FAIL %s vs_low_ticks got %0d want %0d", tag, vs_low, VSY * HT); end
    tests_run++;
    if (blank_hi != HA * VA) begin tests_failed++;
      $display("[TB] FAIL %s visible_ticks got %0d want %0d", tag, blank_hi, HA * VA); end
    tests_run++;
    if (fs_seen != 1) begin tests_failed++;
      $display("[TB] FAIL %s frame_start_pulses got %0d want 1", tag, fs_seen); end
    if (mode == 2) begin
      tests_run++;
      if ({first_vis_seen, first_vis_r} !== {1'b1, 8'(HVS)}) begin tests_failed++;
        $display("[TB] FAIL %s first_visible_r got %0d (seen=%0b) want %0d", tag,
                 first_vis_r, first_vis_seen, HVS); end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({s_clk, s_x, s_y, s_hs, s_vs, s_blank_n, s_r, s_g, s_b, s_fs, s_fc, s_sync_n} !== RESET_VEC) begin
      tests_failed++;
      $display("[TB] FAIL reset_state got %h want %h",
               {s_clk, s_x, s_y, s_hs, s_vs, s_blank_n, s_r, s_g, s_b, s_fs, s_fc, s_sync_n}, RESET_VEC);
    end
    tests_run++;
    if ({d_clk, d_x, d_y, d_hs, d_vs, d_blank_n, d_r, d_g, d_b, d_fs, d_fc, d_sync_n} !== RESET_VEC) begin
      tests_failed++;
      $display("[TB] FAIL reset_state_default got %h want %h",
               {d_clk, d_x, d_y, d_hs, d_vs, d_blank_n, d_r, d_g, d_b, d_fs, d_fc, d_sync_n}, RESET_VEC);
    end
  endtask

  task automatic test_default_line();
    int t, q, hs_low = 0, first_low = -1, blank_hi = 0, nonzero_rgb = 0;
    logic ehs_n;
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int e = 0; e <= 2 * D_HT + 8; e++) begin
      t = e / 2;
      q = t - 1 - D_PD;
      ehs_n = !((q >= 0) && ((q % D_HT) < 96));
      tests_run++;
      if ({d_clk, d_x, d_y, d_hs} !== {1'(e % 2), 10'(t % D_HT), 10'(t / D_HT), ehs_n}) begin
        tests_failed++;
        $display("[TB] FAIL default_line e=%0d got clk=%0b x=%0d y=%0d hs=%0b want clk=%0b x=%0d y=%0d hs=%0b",
                 e, d_clk, d_x, d_y, d_hs, 1'(e % 2), t % D_HT, t / D_HT, ehs_n);
      end
      if ((e % 2 == 0) && (t >= 1) && (t <= D_HT)) begin
        if (d_hs == 1'b0) begin
          hs_low++;
          if (first_low < 0) first_low = t;
        end
        if (d_blank_n == 1'b1) blank_hi++;
        if ({d_r, d_g, d_b} != 24'd0) nonzero_rgb++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    tests_run++;
    if ({hs_low, first_low} != {32'd96, 32'(1 + D_PD)}) begin tests_failed++;
      $display("[TB] FAIL default_hs_pulse got %0d ticks from t=%0d want 96 from t=%0d",
               hs_low, first_low, 1 + D_PD); end
    tests_run++;
    if ({blank_hi, nonzero_rgb} != 64'd0) begin tests_failed++;
      $display("[TB] FAIL default_line0_blank got visible=%0d coloured=%0d want 0 and 0",
               blank_hi, nonzero_rgb); end
    tests_run++;
    if ({d_vs, d_fs, d_fc} !== {1'b0, 1'b0, 16'd0}) begin tests_failed++;
      $display("[TB] FAIL default_vs_frame got vs=%0b fs=%0b fc=%0d want vs=0 fs=0 fc=0",
               d_vs, d_fs, d_fc); end
  endtask

  task automatic test_frame_hash();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_frames_checked(0, FULL_RUN, "hash");
  endtask

  task automatic test_white();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_frames_checked(1, FULL_RUN, "white");
  endtask

  task automatic test_x_ramp();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_frames_checked(2, FULL_RUN, "xramp");
  endtask

  task automatic test_midreset();
    int n;
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = int'($urandom_range(200, 600));
    for (int i = 0; i < n; i++) begin
      {r_in, g_in, b_in} = 24'($urandom);
      @(negedge clk);
    end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #2;
    tests_run++;
    if ({s_clk, s_x, s_y, s_hs, s_vs, s_blank_n, s_r, s_g, s_b, s_fs, s_fc, s_sync_n} !== RESET_VEC) begin
      tests_failed++;
      $display("[TB] FAIL midreset_immediate after %0d cycles got %h want %h", n,
               {s_clk, s_x, s_y, s_hs, s_vs, s_blank_n, s_r, s_g, s_b, s_fs, s_fc, s_sync_n}, RESET_VEC);
    end
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({s_clk, s_x, s_y, s_hs, s_vs, s_blank_n, s_r, s_g, s_b, s_fs, s_fc, s_sync_n} !== RESET_VEC) begin
      tests_failed++;
      $display("[TB] FAIL midreset_hold got %h want %h",
               {s_clk, s_x, s_y, s_hs, s_vs, s_blank_n, s_r, s_g, s_b, s_fs, s_fc, s_sync_n}, RESET_VEC);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_frames_checked(0, FULL_RUN, "after_midreset");
  endtask

  initial begin
    seed_r = 8'($urandom);
    seed_g = 8'($urandom);
    seed_b = 8'($urandom);
    test_reset();
    test_default_line();
    test_frame_hash();
    test_white();
    test_x_ramp();
    test_midreset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
